// File: rtl/io_bus_pkg.sv
// Shared encodings and types for the memory_io bus arbiter.
// Command codes, FSM state type and default error read data.
package io_bus_pkg;

  localparam logic [1:0] IO_CMD_IDLE  = 2'b00;
  localparam logic [1:0] IO_CMD_READ  = 2'b01;
  localparam logic [1:0] IO_CMD_WRITE = 2'b10;

  localparam logic [15:0] IO_DEFAULT_ERROR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } io_arb_state_t;

endpackage

// File: rtl/io_bus_arbiter_rr_select.sv
// Round-robin priority picker: first set request from ptr upward.
// In: req, ptr. Out: one-hot grant, grant_idx, any_req.
module rr_priority_select
  import io_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_req
);

  logic [PW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing memory_io between NUM_REQ requesters.
// Ports: req_* / resp_* per requester, *_io and io_done to memory.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [15:0] ERROR_DATA     = IO_DEFAULT_ERROR_DATA
) (
  input  logic                  main_clk,
  input  logic                  main_rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_address,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_accept,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_data,
  output logic                  resp_error,
  output logic [15:0]           data_out_io,
  input  logic [15:0]           data_in_io,
  output logic [31:0]           address_io,
  output logic [1:0]            control_io,
  input  logic                  io_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

  io_arb_state_t state;
  io_arb_state_t state_nxt;

  logic [NUM_REQ-1:0] sel_grant;
  logic [PW-1:0]      sel_idx;
  logic               sel_any;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] lat_g;
  logic [31:0]   lat_addr;
  logic [15:0]   lat_data;
  logic          lat_write;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          cnt_term;
  logic [15:0]   rsp_data;
  logic          rsp_err;

  logic [31:0] addr_arr [NUM_REQ];
  logic [15:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_address[32*i +: 32];
    assign data_arr[i] = req_data[16*i +: 16];
  end

  rr_priority_select #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_sel (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (sel_grant),
    .grant_idx (sel_idx),
    .any_req   (sel_any)
  );

  assign cnt_inc  = cnt + CW'(1);
  assign cnt_term = (cnt_inc == CNT_TERM);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (sel_any) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT:    if (io_done || cnt_term)
                    state_nxt = ST_RESPOND;
      ST_RESPOND: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // All outputs decode from state so an async reset clears
  // them, including the memory command, without a clock edge.
  always_comb begin
    req_accept  = '0;
    resp_valid  = '0;
    resp_data   = '0;
    resp_error  = 1'b0;
    control_io  = IO_CMD_IDLE;
    address_io  = '0;
    data_out_io = '0;
    if (state == ST_IDLE)
      req_accept = sel_grant;
    if (state == ST_ISSUE)
      control_io = lat_write ? IO_CMD_WRITE
                             : IO_CMD_READ;
    if (state != ST_IDLE) begin
      address_io  = lat_addr;
      data_out_io = lat_data;
    end
    if (state == ST_RESPOND) begin
      resp_valid = NUM_REQ'(1) << lat_g;
      resp_data  = rsp_data;
      resp_error = rsp_err;
    end
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      lat_g     <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: begin
          if (sel_any) begin
            lat_g     <= sel_idx;
            lat_addr  <= addr_arr[sel_idx];
            lat_data  <= data_arr[sel_idx];
            lat_write <= req_write[sel_idx];
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          // io_done beats the timeout on the terminal cycle.
          if (io_done) begin
            rsp_data <= lat_write ? 16'h0000
                                  : data_in_io;
            rsp_err  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_term) begin
              rsp_data <= ERROR_DATA;
              rsp_err  <= 1'b1;
            end
          end
        end
        ST_RESPOND: begin
          rr_ptr <= (lat_g == LAST_REQ) ? '0
                                        : lat_g + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter.
// Two requesters, TIMEOUT_CYCLES=8, one task per scenario.
module tb_io_bus_arbiter;

  logic        main_clk = 1'b0;
  logic        main_rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [63:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_accept;
  logic [1:0]  resp_valid;
  logic [15:0] resp_data;
  logic        resp_error;
  logic [15:0] data_out_io;
  logic [15:0] data_in_io = '0;
  logic [31:0] address_io;
  logic [1:0]  control_io;
  logic        io_done = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 main_clk = ~main_clk;

  io_bus_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8),
    .ERROR_DATA     (16'hFFFF)
  ) dut (
    .main_clk    (main_clk),
    .main_rst_n  (main_rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_address (req_address),
    .req_data    (req_data),
    .req_accept  (req_accept),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_error  (resp_error),
    .data_out_io (data_out_io),
    .data_in_io  (data_in_io),
    .address_io  (address_io),
    .control_io  (control_io),
    .io_done     (io_done)
  );

  task automatic step();
    @(posedge main_clk);
    #2;
  endtask

  task automatic apply_reset();
    main_rst_n = 1'b0;
    #1;
    step();
    main_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({req_accept, resp_valid, resp_error} !== 5'b0)
      $display("FAIL reset_flags got %b want 0",
               {req_accept, resp_valid, resp_error});
    else passed++;
    total++;
    if (control_io !== 2'b00)
      $display("FAIL reset_ctrl got %b want 00", control_io);
    else passed++;
    total++;
    if ({address_io, data_out_io, resp_data} !== 64'h0)
      $display("FAIL reset_bus got %h want 0",
               {address_io, data_out_io, resp_data});
    else passed++;
    step();
    main_rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    req_valid = 2'b01;
    req_write = 2'b00;
    req_address[31:0] = 32'h0000_1000;
    #1;
    total++;
    if (req_accept !== 2'b01)
      $display("FAIL sr_accept got %b want 01", req_accept);
    else passed++;
    step();
    req_valid = 2'b00;
    total++;
    if (control_io !== 2'b01)
      $display("FAIL sr_cmd got %b want 01", control_io);
    else passed++;
    total++;
    if (address_io !== 32'h0000_1000)
      $display("FAIL sr_addr got %h want 1000", address_io);
    else passed++;
    step();
    total++;
    if (control_io !== 2'b00)
      $display("FAIL sr_cmd_one got %b want 00", control_io);
    else passed++;
    step();
    step();
    io_done = 1'b1;
    data_in_io = 16'hBEEF;
    #1;
    total++;
    if (resp_valid !== 2'b00)
      $display("FAIL sr_early got %b want 00", resp_valid);
    else passed++;
    step();
    io_done = 1'b0;
    total++;
    if (resp_valid !== 2'b01)
      $display("FAIL sr_rv got %b want 01", resp_valid);
    else passed++;
    total++;
    if ({resp_error, resp_data} !== {1'b0, 16'hBEEF})
      $display("FAIL sr_data got %b/%h want 0/beef",
               resp_error, resp_data);
    else passed++;
    step();
    total++;
    if (resp_valid !== 2'b00)
      $display("FAIL sr_rv_pulse got %b want 00", resp_valid);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [1:0]  exp_g;
    logic [1:0]  exp_c;
    logic [31:0] exp_a;
    logic [15:0] exp_d;
    apply_reset();
    req_valid   = 2'b11;
    req_write   = 2'b01;
    req_address = {32'h0000_0020, 32'h0000_0010};
    req_data    = {16'h0000, 16'h1234};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_c = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_a = (k % 2 == 0) ? 32'h10 : 32'h20;
      exp_d = (k % 2 == 0) ? 16'h0 : 16'hA000 + 16'(k);
      #1;
      total++;
      if (req_accept !== exp_g)
        $display("FAIL sim_accept%0d got %b want %b",
                 k, req_accept, exp_g);
      else passed++;
      step();
      total++;
      if ({control_io, address_io} !== {exp_c, exp_a})
        $display("FAIL sim_cmd%0d got %b/%h want %b/%h",
                 k, control_io, address_io, exp_c, exp_a);
      else passed++;
      if (k == 0) begin
        total++;
        if (data_out_io !== 16'h1234)
          $display("FAIL sim_wdata got %h want 1234",
                   data_out_io);
        else passed++;
      end
      step();
      io_done = 1'b1;
      data_in_io = 16'hA000 + 16'(k);
      step();
      io_done = 1'b0;
      total++;
      if ({resp_valid, resp_data} !== {exp_g, exp_d})
        $display("FAIL sim_resp%0d got %b/%h want %b/%h",
                 k, resp_valid, resp_data, exp_g, exp_d);
      else passed++;
      step();
    end
    req_valid = 2'b00;
    req_write = 2'b00;
  endtask

  task automatic test_timeout();
    req_valid = 2'b01;
    req_address[31:0] = 32'h40;
    #1;
    total++;
    if (req_accept !== 2'b01)
      $display("FAIL to_accept got %b want 01", req_accept);
    else passed++;
    step();
    req_valid = 2'b00;
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (resp_valid !== 2'b00)
        $display("FAIL to_wait%0d got %b want 00",
                 i, resp_valid);
      else passed++;
      step();
    end
    total++;
    if ({resp_valid, resp_error, resp_data} !==
        {2'b01, 1'b1, 16'hFFFF})
      $display("FAIL to_resp got %b/%b/%h want 01/1/ffff",
               resp_valid, resp_error, resp_data);
    else passed++;
    step();
    req_valid = 2'b10;
    req_address[63:32] = 32'h80;
    #1;
    total++;
    if (req_accept !== 2'b10)
      $display("FAIL to_next_acc got %b want 10", req_accept);
    else passed++;
    step();
    req_valid = 2'b00;
    total++;
    if ({control_io, address_io} !== {2'b01, 32'h80})
      $display("FAIL to_next_cmd got %b/%h want 01/80",
               control_io, address_io);
    else passed++;
    step();
    io_done = 1'b1;
    data_in_io = 16'h5A5A;
    step();
    io_done = 1'b0;
    total++;
    if ({resp_valid, resp_error, resp_data} !==
        {2'b10, 1'b0, 16'h5A5A})
      $display("FAIL to_next_resp got %b/%b/%h want 10/0/5a5a",
               resp_valid, resp_error, resp_data);
    else passed++;
    step();
  endtask

  task automatic test_tie();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    repeat (7) step();
    io_done = 1'b1;
    data_in_io = 16'hC3C3;
    #1;
    total++;
    if (resp_valid !== 2'b00)
      $display("FAIL tie_early got %b want 00", resp_valid);
    else passed++;
    step();
    io_done = 1'b0;
    total++;
    if ({resp_valid, resp_error, resp_data} !==
        {2'b01, 1'b0, 16'hC3C3})
      $display("FAIL tie_resp got %b/%b/%h want 01/0/c3c3",
               resp_valid, resp_error, resp_data);
    else passed++;
    step();
  endtask

  task automatic test_reset_wait();
    req_valid = 2'b10;
    req_address[63:32] = 32'h99;
    step();
    req_valid = 2'b00;
    step();
    step();
    #3;
    main_rst_n = 1'b0;
    #1;
    total++;
    if ({control_io, resp_valid, resp_error} !== 5'b0)
      $display("FAIL rw_flags got %b want 0",
               {control_io, resp_valid, resp_error});
    else passed++;
    total++;
    if ({address_io, data_out_io} !== 48'h0)
      $display("FAIL rw_bus got %h want 0",
               {address_io, data_out_io});
    else passed++;
    step();
    main_rst_n = 1'b1;
    io_done = 1'b1;
    step();
    io_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (resp_valid !== 2'b00)
        $display("FAIL rw_noresp%0d got %b want 00",
                 i, resp_valid);
      else passed++;
      step();
    end
    req_valid = 2'b11;
    #1;
    total++;
    if (req_accept !== 2'b01)
      $display("FAIL rw_ptr got %b want 01", req_accept);
    else passed++;
    step();
    req_valid = 2'b00;
    step();
    io_done = 1'b1;
    step();
    io_done = 1'b0;
    total++;
    if (resp_valid !== 2'b01)
      $display("FAIL rw_after got %b want 01", resp_valid);
    else passed++;
    step();
  endtask

  task automatic test_stray_done();
    io_done = 1'b1;
    step();
    io_done = 1'b0;
    total++;
    if ({resp_valid, control_io} !== 4'b0)
      $display("FAIL sd_resp got %b want 0",
               {resp_valid, control_io});
    else passed++;
    step();
    total++;
    if (resp_valid !== 2'b00)
      $display("FAIL sd_resp2 got %b want 00", resp_valid);
    else passed++;
    req_valid = 2'b10;
    #1;
    total++;
    if (req_accept !== 2'b10)
      $display("FAIL sd_idle got %b want 10", req_accept);
    else passed++;
    step();
    req_valid = 2'b00;
    step();
    io_done = 1'b1;
    step();
    io_done = 1'b0;
    total++;
    if (resp_valid !== 2'b10)
      $display("FAIL sd_after got %b want 10", resp_valid);
    else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_timeout();
    test_tie();
    test_reset_wait();
    test_stray_done();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
